// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin
// identifiers, status codes and coin values.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PAY,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  // Encoding matches the refill_coin input (3 = ignored).
  typedef enum logic [1:0] {
    COIN_1  = 2'd0,
    COIN_5  = 2'd1,
    COIN_10 = 2'd2
  } coin_t;

  localparam logic [1:0] STATUS_OK       = 2'b00;
  localparam logic [1:0] STATUS_NO_STOCK = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;

  localparam logic [4:0] VALUE_1  = 5'd1;
  localparam logic [4:0] VALUE_5  = 5'd5;
  localparam logic [4:0] VALUE_10 = 5'd10;

  function automatic logic [4:0] coin_value(input coin_t c);
    case (c)
      COIN_10: return VALUE_10;
      COIN_5:  return VALUE_5;
      default: return VALUE_1;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_stock.sv
// Three 4-bit saturating coin stock counters with refill, single-coin
// decrement and empty flags.
module coin_stock
  import change_dispenser_pkg::*;
#(
  parameter int STOCK_INIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refill_valid,
  input  logic [1:0] refill_coin,
  input  logic [3:0] refill_count,
  input  logic       dec_valid,
  input  coin_t      dec_coin,
  output logic [2:0] empty
);

  logic [3:0] stock     [3];
  logic [3:0] stock_nxt [3];
  logic [4:0] sum       [3];

  // Refill and decrement combine first, then saturate, so a same-cycle
  // ack and refill give stock - 1 + refill_count clipped at 15.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum[i]       = {1'b0, stock[i]};
      if (refill_valid && (refill_coin == 2'(i)))
        sum[i] = sum[i] + {1'b0, refill_count};
      if (dec_valid && (2'(dec_coin) == 2'(i)) && (sum[i] != 5'd0))
        sum[i] = sum[i] - 5'd1;
      stock_nxt[i] = (sum[i] > 5'd15) ? 4'd15 : sum[i][3:0];
      empty[i]     = (stock[i] == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) stock[i] <= 4'(STOCK_INIT);
      else       stock[i] <= stock_nxt[i];
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: pays largest eligible coin first and waits for a
// hopper ack per coin. Stock tracking is enabled by CHANGE_DISPENSER_STOCK_EN.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int STOCK_INIT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [4:0] req_amount,
  output logic       req_ready,
  output logic       pay1,
  output logic       pay5,
  output logic       pay10,
  input  logic       hopper_ack,
  input  logic       refill_valid,
  input  logic [1:0] refill_coin,
  input  logic [3:0] refill_count,
  output logic       done,
  output logic [1:0] status,
  output logic [4:0] owed,
  output state_t     state_dbg
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

  // Request handshake: a request transfers on a cycle where req_valid and
  // req_ready are both high; req_ready is high only in IDLE.
  state_t          state, state_nxt;
  logic [4:0]      remaining, remaining_nxt;
  coin_t           coin_sel, coin_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic [1:0]      status_r, status_nxt;
  logic            dec_valid;
  logic [2:0]      empty;

`ifdef CHANGE_DISPENSER_STOCK_EN
  coin_stock #(.STOCK_INIT(STOCK_INIT)) u_stock (
    .clk          (clk),
    .reset        (reset),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .refill_count (refill_count),
    .dec_valid    (dec_valid),
    .dec_coin     (coin_sel),
    .empty        (empty)
  );
`else
  logic unused_stock;
  assign empty        = 3'b000;
  assign unused_stock = ^{refill_valid, refill_coin, refill_count, dec_valid};
`endif

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= 5'd0;
      coin_sel  <= COIN_1;
      tcnt      <= '0;
      status_r  <= STATUS_OK;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      coin_sel  <= coin_nxt;
      tcnt      <= tcnt_nxt;
      status_r  <= status_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    coin_nxt      = coin_sel;
    tcnt_nxt      = tcnt;
    status_nxt    = status_r;
    dec_valid     = 1'b0;
    req_ready     = 1'b0;
    pay1          = 1'b0;
    pay5          = 1'b0;
    pay10         = 1'b0;
    done          = 1'b0;
    status        = STATUS_OK;
    owed          = 5'd0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          remaining_nxt = req_amount;
          status_nxt    = STATUS_OK;
          state_nxt     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (remaining == 5'd0) begin
          state_nxt = S_DONE;
        end else if ((remaining >= VALUE_10) && !empty[COIN_10]) begin
          coin_nxt  = COIN_10;
          state_nxt = S_PAY;
        end else if ((remaining >= VALUE_5) && !empty[COIN_5]) begin
          coin_nxt  = COIN_5;
          state_nxt = S_PAY;
        end else if (!empty[COIN_1]) begin
          coin_nxt  = COIN_1;
          state_nxt = S_PAY;
        end else begin
          status_nxt = STATUS_NO_STOCK;
          state_nxt  = S_DONE;
        end
      end
      S_PAY: begin
        case (coin_sel)
          COIN_10: pay10 = 1'b1;
          COIN_5:  pay5  = 1'b1;
          default: pay1  = 1'b1;
        endcase
        tcnt_nxt  = '0;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An ack in the final timeout cycle still wins over expiry.
        if (hopper_ack) begin
          remaining_nxt = remaining - coin_value(coin_sel);
          dec_valid     = 1'b1;
          state_nxt     = S_SELECT;
        end else if (tcnt == TLAST) begin
          status_nxt = STATUS_TIMEOUT;
          state_nxt  = S_DONE;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      S_DONE: begin
        done      = 1'b1;
        status    = status_r;
        owed      = remaining;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser (STOCK_INIT = 2); stock-dependent
// steps follow CHANGE_DISPENSER_STOCK_EN.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam logic [2:0] P10 = 3'b100;
  localparam logic [2:0] P5  = 3'b010;
  localparam logic [2:0] P1  = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [4:0] req_amount = 5'd0;
  logic       req_ready;
  logic       pay1, pay5, pay10;
  logic       hopper_ack = 1'b0;
  logic       refill_valid = 1'b0;
  logic [1:0] refill_coin = 2'd0;
  logic [3:0] refill_count = 4'd0;
  logic       done;
  logic [1:0] status;
  logic [4:0] owed;
  state_t     state_dbg;

  int nvec = 0;
  int nerr = 0;
  logic [2:0] exp_pay;

  change_dispenser #(.ACK_TIMEOUT(16), .STOCK_INIT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .pay1         (pay1),
    .pay5         (pay5),
    .pay10        (pay10),
    .hopper_ack   (hopper_ack),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .refill_count (refill_count),
    .done         (done),
    .status       (status),
    .owed         (owed),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot_pay", 32'($onehot0({pay10, pay5, pay1})), 32'd1);
  endtask

  task automatic start_req(input logic [4:0] amt);
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_amount = amt;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic wait_pay(input string tag, input logic [2:0] exp);
    int n = 0;
    while ({pay10, pay5, pay1} == 3'b000 && n < 10) begin
      step();
      n++;
    end
    chk(tag, 32'({pay10, pay5, pay1}), 32'(exp));
  endtask

  task automatic pay_expect(input string tag, input logic [2:0] exp, input int lat);
    wait_pay(tag, exp);
    step();
    chk("pay_pulse_len", 32'({pay10, pay5, pay1}), 32'd0);
    repeat (lat) step();
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] st, input logic [4:0] ow);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_status"}, 32'(status), 32'(st));
    chk({tag, "_owed"}, 32'(owed), 32'(ow));
    step();
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

`ifdef CHANGE_DISPENSER_STOCK_EN
  task automatic chk_stock(input string tag, input int s1, input int s5, input int s10);
    chk({tag, "_s1"}, 32'(dut.u_stock.stock[0]), 32'(s1));
    chk({tag, "_s5"}, 32'(dut.u_stock.stock[1]), 32'(s5));
    chk({tag, "_s10"}, 32'(dut.u_stock.stock[2]), 32'(s10));
  endtask
`endif

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_ready", 32'(req_ready), 32'd1);
`ifdef CHANGE_DISPENSER_STOCK_EN
    chk_stock("rst", 2, 2, 2);
`endif
  endtask

  task automatic refill(input logic [1:0] coin, input logic [3:0] cnt);
    refill_valid = 1'b1;
    refill_coin  = coin;
    refill_count = cnt;
    step();
    refill_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("r_ready", 32'(req_ready), 32'd1);
    chk("r_done", 32'(done), 32'd0);
    chk("r_status", 32'(status), 32'd0);
    chk("r_owed", 32'(owed), 32'd0);
    chk("r_pays", 32'({pay10, pay5, pay1}), 32'd0);
    chk("r_state", 32'(state_dbg), 32'(S_IDLE));

    // 17 lei: 10, 5, 1, 1
    start_req(5'd17);
    pay_expect("p17_a", P10, 0);
    pay_expect("p17_b", P5, 0);
    pay_expect("p17_c", P1, 0);
    pay_expect("p17_d", P1, 2);
    wait_done("d17", STATUS_OK, 5'd0);
`ifdef CHANGE_DISPENSER_STOCK_EN
    chk_stock("after17", 0, 1, 1);
`endif

    // Zero amount: done two cycles after acceptance, no pay
    start_req(5'd0);
    chk("z_sel_done", 32'(done), 32'd0);
    chk("z_sel_state", 32'(state_dbg), 32'(S_SELECT));
    step();
    chk("z_done", 32'(done), 32'd1);
    chk("z_status", 32'(status), 32'(STATUS_OK));
    chk("z_owed", 32'(owed), 32'd0);
    chk("z_pays", 32'({pay10, pay5, pay1}), 32'd0);
    step();
    chk("z_done_drop", 32'(done), 32'd0);

`ifdef CHANGE_DISPENSER_STOCK_EN
    do_reset();
    start_req(5'd20);
    pay_expect("p20_a", P10, 0);
    pay_expect("p20_b", P10, 0);
    wait_done("d20", STATUS_OK, 5'd0);
    chk_stock("after20", 2, 2, 0);
    // No 10s left: 10 lei paid as two 5s
    start_req(5'd10);
    pay_expect("p10_a", P5, 0);
    pay_expect("p10_b", P5, 0);
    wait_done("d10", STATUS_OK, 5'd0);
    chk_stock("after10", 2, 0, 0);
    // Only two 1s left: insufficient stock
    start_req(5'd3);
    pay_expect("p3_a", P1, 0);
    pay_expect("p3_b", P1, 0);
    wait_done("d3", STATUS_NO_STOCK, 5'd1);
    chk_stock("after3", 0, 0, 0);
    refill(2'd1, 4'd8);
    chk_stock("ref5", 0, 8, 0);
    refill(2'd3, 4'd15);
    chk_stock("ref_ign", 0, 8, 0);
    refill(2'd2, 4'd15);
    refill(2'd2, 4'd15);
    chk_stock("ref10_sat", 0, 8, 15);
    // Ack and refill on the same coin in one cycle
    start_req(5'd5);
    wait_pay("p5_sat", P5);
    step();
    hopper_ack   = 1'b1;
    refill_valid = 1'b1;
    refill_coin  = 2'd1;
    refill_count = 4'd10;
    step();
    hopper_ack   = 1'b0;
    refill_valid = 1'b0;
    wait_done("d5_sat", STATUS_OK, 5'd0);
    chk_stock("ack_ref", 0, 15, 15);
`else
    refill(2'd0, 4'd15);
    start_req(5'd20);
    pay_expect("p20_a", P10, 0);
    pay_expect("p20_b", P10, 0);
    wait_done("d20", STATUS_OK, 5'd0);
`endif

    // Hopper timeout: 16 silent WAIT_ACK cycles
    do_reset();
    start_req(5'd6);
    wait_pay("t6_pay", P5);
    repeat (16) step();
    chk("t6_still_wait", 32'(state_dbg), 32'(S_WAIT_ACK));
    chk("t6_no_done", 32'(done), 32'd0);
    step();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_status", 32'(status), 32'(STATUS_TIMEOUT));
    chk("t6_owed", 32'(owed), 32'd6);
    step();
    chk("t6_ready", 32'(req_ready), 32'd1);
`ifdef CHANGE_DISPENSER_STOCK_EN
    chk_stock("t6", 2, 2, 2);
`endif

    // Ack in the last timeout cycle counts as an ack
    start_req(5'd6);
    wait_pay("e6_pay", P5);
    repeat (16) step();
    chk("e6_wait", 32'(state_dbg), 32'(S_WAIT_ACK));
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
    chk("e6_select", 32'(state_dbg), 32'(S_SELECT));
    chk("e6_no_done", 32'(done), 32'd0);
    pay_expect("e6_p1", P1, 0);
    wait_done("e6", STATUS_OK, 5'd0);
`ifdef CHANGE_DISPENSER_STOCK_EN
    chk_stock("e6", 1, 1, 2);
`endif

    // Ack while idle is ignored
    hopper_ack = 1'b1;
    repeat (3) step();
    hopper_ack = 1'b0;
    chk("ia_state", 32'(state_dbg), 32'(S_IDLE));
    chk("ia_done", 32'(done), 32'd0);
`ifdef CHANGE_DISPENSER_STOCK_EN
    chk_stock("ia", 1, 1, 2);
`endif

    // Maximum amount
    start_req(5'd31);
    pay_expect("p31_a", P10, 0);
    pay_expect("p31_b", P10, 0);
`ifdef CHANGE_DISPENSER_STOCK_EN
    pay_expect("p31_c", P5, 1);
    pay_expect("p31_d", P1, 0);
    wait_done("d31", STATUS_NO_STOCK, 5'd5);
    refill(2'd0, 4'd5);
    exp_pay = P1;
`else
    pay_expect("p31_c", P10, 1);
    pay_expect("p31_d", P1, 0);
    wait_done("d31", STATUS_OK, 5'd0);
    exp_pay = P10;
`endif

    // Reset in WAIT_ACK aborts with no done pulse
    start_req(5'd10);
    wait_pay("ra_pay", exp_pay);
    step();
    chk("ra_wait", 32'(state_dbg), 32'(S_WAIT_ACK));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ra_state", 32'(state_dbg), 32'(S_IDLE));
    chk("ra_ready", 32'(req_ready), 32'd1);
    chk("ra_done", 32'(done), 32'd0);
`ifdef CHANGE_DISPENSER_STOCK_EN
    chk_stock("ra", 2, 2, 2);
`endif
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ra_no_done", 32'(done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
